mem_access_unit: RTL and testbench

MEM-stage controller of the pipelined MIPS core, sitting on the consuming end of the EX/MEM register. It takes the registered EX/MEM control and data bundle, runs a variable-latency req/ack transaction on the data-memory port, and raises a stall that freezes PC, IF/ID, ID/EX and EX/MEM while a transaction is in flight. It also contains the MEM/WB pipeline register, so its outputs feed write-back directly.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_wb_reg.sv | 24 ++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, default widths and the MEM/WB bundle.
package mem_stage_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [DEF_DATA_W-1:0] read_data;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_REG_W-1:0]  write_reg;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack port; the MEM stage drives the request side.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears only the write-back controls so no write repeats.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= MEM_WB_BUBBLE;
        end else if (bubble) begin
            q.reg_write  <= 1'b0;
            q.mem_to_reg <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: runs the variable-latency data-memory transaction, stalls upstream
// while it is in flight, and owns the MEM/WB register.
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_W       = DEF_REG_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_write_in,
    input  logic                   mem_read_in,
    input  logic                   reg_write_in,
    input  logic                   mem_to_reg_in,
    input  logic [REG_W-1:0]       mux_reg_dst_out_in,
    input  logic [DATA_W-1:0]      ALU_result_in,
    input  logic [DATA_W-1:0]      mux_ALU_src_B_out_in,
    mem_access_unit_if.master      dmem,
    output logic                   mem_stall,
    output logic                   reg_write_out,
    output logic                   mem_to_reg_out,
    output logic [DATA_W-1:0]      read_data_out,
    output logic [DATA_W-1:0]      ALU_result_out,
    output logic [REG_W-1:0]       write_reg_out,
    output logic                   misalign_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    state_t            state;
    logic              access;
    logic              aligned;
    logic              start;
    logic              misaligned;
    logic              we_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_W-1:0]  write_reg_q;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;

    assign access     = mem_read_in | mem_write_in;
    assign aligned    = (ALU_result_in[1:0] == 2'b00);
    assign start      = (state == IDLE) && access && aligned;
    assign misaligned = (state == IDLE) && access && !aligned;

    // Gated by rst_n so the stall drops the moment reset is asserted, not at the next edge.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst_n) begin
            mem_stall = 1'b0;
        end else if (state == IDLE) begin
            mem_stall = start;
        end else begin
            mem_stall = !dmem.dmem_ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_reg_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= BUSY;
                        we_q         <= mem_write_in;
                        reg_write_q  <= reg_write_in;
                        mem_to_reg_q <= mem_to_reg_in;
                        addr_q       <= ALU_result_in;
                        wdata_q      <= mux_ALU_src_B_out_in;
                        write_reg_q  <= mux_reg_dst_out_in;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = (state == BUSY);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
            stall_cycles <= '0;
        end else begin
            misalign_err <= misaligned;
            if (mem_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

    // Misaligned accesses fall through to the all-zero bubble; stall edges are handled in mem_wb_reg.
    always_comb begin
        wb_d = MEM_WB_BUBBLE;
        if (state == BUSY) begin
            wb_d.reg_write  = reg_write_q;
            wb_d.mem_to_reg = mem_to_reg_q;
            wb_d.read_data  = we_q ? '0 : dmem.dmem_rdata;
            wb_d.alu_result = addr_q;
            wb_d.write_reg  = write_reg_q;
        end else if (!misaligned) begin
            wb_d.reg_write  = reg_write_in;
            wb_d.mem_to_reg = mem_to_reg_in;
            wb_d.read_data  = '0;
            wb_d.alu_result = ALU_result_in;
            wb_d.write_reg  = mux_reg_dst_out_in;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (!mem_stall),
        .bubble (mem_stall),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign reg_write_out  = wb_q.reg_write;
    assign mem_to_reg_out = wb_q.mem_to_reg;
    assign read_data_out  = wb_q.read_data;
    assign ALU_result_out = wb_q.alu_result;
    assign write_reg_out  = wb_q.write_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; the 4-bit stall counter makes saturation reachable.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_write_in;
    logic        mem_read_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [4:0]  mux_reg_dst_out_in;
    logic [31:0] ALU_result_in;
    logic [31:0] mux_ALU_src_B_out_in;
    logic        mem_stall;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic [31:0] read_data_out;
    logic [31:0] ALU_result_out;
    logic [4:0]  write_reg_out;
    logic        misalign_err;
    logic [3:0]  stall_cycles;

    int errors = 0;
    int checks = 0;

    mem_access_unit_if #(.DATA_W(32)) dmem_bus ();

    mem_access_unit #(
        .DATA_W      (32),
        .REG_W       (5),
        .STALL_CNT_W (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mem_write_in         (mem_write_in),
        .mem_read_in          (mem_read_in),
        .reg_write_in         (reg_write_in),
        .mem_to_reg_in        (mem_to_reg_in),
        .mux_reg_dst_out_in   (mux_reg_dst_out_in),
        .ALU_result_in        (ALU_result_in),
        .mux_ALU_src_B_out_in (mux_ALU_src_B_out_in),
        .dmem                 (dmem_bus),
        .mem_stall            (mem_stall),
        .reg_write_out        (reg_write_out),
        .mem_to_reg_out       (mem_to_reg_out),
        .read_data_out        (read_data_out),
        .ALU_result_out       (ALU_result_out),
        .write_reg_out        (write_reg_out),
        .misalign_err         (misalign_err),
        .stall_cycles         (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr, input logic rw,
                                  input logic mtr, input logic [4:0] dst,
                                  input logic [31:0] alu, input logic [31:0] wdat);
        mem_read_in          = rd;
        mem_write_in         = wr;
        reg_write_in         = rw;
        mem_to_reg_in        = mtr;
        mux_reg_dst_out_in   = dst;
        ALU_result_in        = alu;
        mux_ALU_src_B_out_in = wdat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n               = 1'b0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        // Reset state
        #12;
        check_output("rst_req",     32'(dmem_bus.dmem_req), 32'd0);
        check_output("rst_stall",   32'(mem_stall), 32'd0);
        check_output("rst_cnt",     32'(stall_cycles), 32'd0);
        check_output("rst_rw",      32'(reg_write_out), 32'd0);
        check_output("rst_misalgn", 32'(misalign_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Pass-through
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
        @(negedge clk);
        check_output("pt_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        check_output("pt_alu", ALU_result_out, 32'h1234);
        check_output("pt_wreg", 32'(write_reg_out), 32'd5);
        check_output("pt_rw", 32'(reg_write_out), 32'd1);
        check_output("pt_rdata", read_data_out, 32'h0);
        check_output("pt_req", 32'(dmem_bus.dmem_req), 32'd0);

        // Zero-wait load
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h40, 32'h0);
        @(negedge clk);
        check_output("ld_stall_idle", 32'(mem_stall), 32'd1);
        next_cycle();
        check_output("ld_req", 32'(dmem_bus.dmem_req), 32'd1);
        check_output("ld_bubble_rw", 32'(reg_write_out), 32'd0);
        check_output("ld_cnt_mid", 32'(stall_cycles), 32'd1);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_output("ld_stall_ack", 32'(mem_stall), 32'd0);
        check_output("ld_addr", dmem_bus.dmem_addr, 32'h40);
        check_output("ld_we", 32'(dmem_bus.dmem_we), 32'd0);
        next_cycle();
        dmem_bus.dmem_ack = 1'b0;
        check_output("ld_rdata", read_data_out, 32'hDEADBEEF);
        check_output("ld_mtr", 32'(mem_to_reg_out), 32'd1);
        check_output("ld_rw", 32'(reg_write_out), 32'd1);
        check_output("ld_alu", ALU_result_out, 32'h40);
        check_output("ld_wreg", 32'(write_reg_out), 32'd7);
        check_output("ld_req_drop", 32'(dmem_bus.dmem_req), 32'd0);
        check_output("ld_cnt", 32'(stall_cycles), 32'd1);

        // Wait-state store, ack in the third BUSY cycle
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'hCAFE);
        @(negedge clk);
        check_output("st_stall_idle", 32'(mem_stall), 32'd1);
        next_cycle();
        check_output("st_hold_rdata", read_data_out, 32'hDEADBEEF);
        check_output("st_bubble_rw0", 32'(reg_write_out), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = 32'h55;
            end
            @(negedge clk);
            check_output($sformatf("st_req_%0d", i), 32'(dmem_bus.dmem_req), 32'd1);
            check_output($sformatf("st_we_%0d", i), 32'(dmem_bus.dmem_we), 32'd1);
            check_output($sformatf("st_addr_%0d", i), dmem_bus.dmem_addr, 32'h80);
            check_output($sformatf("st_wdata_%0d", i), dmem_bus.dmem_wdata, 32'hCAFE);
            check_output($sformatf("st_stall_%0d", i), 32'(mem_stall), (i < 3) ? 32'd1 : 32'd0);
            next_cycle();
            if (i < 3) begin
                check_output($sformatf("st_bubble_rw_%0d", i), 32'(reg_write_out), 32'd0);
            end
        end
        dmem_bus.dmem_ack = 1'b0;
        check_output("st_alu", ALU_result_out, 32'h80);
        check_output("st_rdata", read_data_out, 32'h0);
        check_output("st_req_drop", 32'(dmem_bus.dmem_req), 32'd0);
        check_output("st_cnt", 32'(stall_cycles), 32'd4);

        // Misaligned load
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h42, 32'h0);
        @(negedge clk);
        check_output("mis_stall", 32'(mem_stall), 32'd0);
        check_output("mis_req", 32'(dmem_bus.dmem_req), 32'd0);
        next_cycle();
        check_output("mis_err", 32'(misalign_err), 32'd1);
        check_output("mis_rw", 32'(reg_write_out), 32'd0);
        check_output("mis_mtr", 32'(mem_to_reg_out), 32'd0);
        check_output("mis_req2", 32'(dmem_bus.dmem_req), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0);
        next_cycle();
        check_output("mis_err_pulse", 32'(misalign_err), 32'd0);
        check_output("mis_next_rw", 32'(reg_write_out), 32'd1);
        check_output("mis_next_alu", ALU_result_out, 32'h10);
        check_output("mis_cnt", 32'(stall_cycles), 32'd4);

        // Reset asserted mid-BUSY, then a stray ack
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h100, 32'h0);
        next_cycle();
        check_output("rb_req", 32'(dmem_bus.dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rb_req_drop", 32'(dmem_bus.dmem_req), 32'd0);
        check_output("rb_stall_drop", 32'(mem_stall), 32'd0);
        check_output("rb_cnt", 32'(stall_cycles), 32'd0);
        check_output("rb_alu", ALU_result_out, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h20, 32'h0);
        @(negedge clk);
        rst_n               = 1'b1;
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h99;
        #1;
        check_output("stray_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        check_output("stray_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_output("stray_rdata", read_data_out, 32'h0);
        check_output("stray_alu", ALU_result_out, 32'h20);
        check_output("stray_wreg", 32'(write_reg_out), 32'd4);
        check_output("stray_cnt", 32'(stall_cycles), 32'd0);
        dmem_bus.dmem_ack = 1'b0;

        // Counter saturation: 20 stall edges on a 4-bit counter
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h200, 32'h77);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
        end
        check_output("sat_stall", 32'(mem_stall), 32'd1);
        check_output("sat_cnt", 32'(stall_cycles), 32'd15);
        dmem_bus.dmem_ack = 1'b1;
        next_cycle();
        dmem_bus.dmem_ack = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check_output("sat_req_drop", 32'(dmem_bus.dmem_req), 32'd0);
        check_output("sat_cnt_hold", 32'(stall_cycles), 32'd15);
        check_output("sat_alu", ALU_result_out, 32'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
